// File: rtl/spi_ram_slave_p.sv
// SPI-framed RAM slave: 2-bit command plus DATA_W payload per frame, with
// address/data write and address/data read commands against an internal memory.
module spi_ram_slave_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int MEM_DEPTH = 2 ** ADDR_W;
  localparam int CW        = 6;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] MEM     = 3'd3;
  localparam logic [2:0] TX      = 3'd4;
  localparam logic [2:0] WAIT_SS = 3'd5;

  logic [2:0]        state_r;
  logic [CW-1:0]     cnt_r;
  logic [1:0]        cmd_r;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] tx_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic              rd_valid_r;
  logic              miso_r;
  logic              busy_r;
  logic              frame_err_r;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              we_s;
  logic              in_frame_s;
  logic [DATA_W-1:0] rd_data_s;

  // Memory write strobe, abort detection and read-data selection.
  always_comb begin
    we_s       = 1'b0;
    in_frame_s = 1'b0;
    rd_data_s  = {DATA_W{1'b0}};
    if ((state_r == MEM) && !SS_n && (cmd_r == 2'b01)) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
    if ((state_r == CMD) || (state_r == PAYLOAD) || (state_r == MEM) || (state_r == TX)) begin
      in_frame_s = 1'b1;
    end else begin
      in_frame_s = 1'b0;
    end
    // A read before any read address has been set returns zeros.
    if (rd_valid_r) begin
      rd_data_s = mem[rd_ptr_r];
    end else begin
      rd_data_s = {DATA_W{1'b0}};
    end
  end

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem[wr_ptr_r] <= shift_r;
    end
  end

  // Frame sequencer, pointers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      cmd_r       <= 2'b00;
      shift_r     <= {DATA_W{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      rd_valid_r  <= 1'b0;
      miso_r      <= 1'b0;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (SS_n && in_frame_s) begin
        state_r     <= IDLE;
        busy_r      <= 1'b0;
        miso_r      <= 1'b0;
        frame_err_r <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            miso_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
            if (!SS_n) begin
              state_r <= CMD;
              busy_r  <= 1'b1;
            end else begin
              busy_r  <= 1'b0;
            end
          end
          CMD: begin
            cmd_r <= {cmd_r[0], MOSI};
            if (cnt_r == CW'(1)) begin
              state_r <= PAYLOAD;
              cnt_r   <= {CW{1'b0}};
            end else begin
              cnt_r   <= cnt_r + CW'(1);
            end
          end
          PAYLOAD: begin
            shift_r <= {shift_r[DATA_W-2:0], MOSI};
            if (cnt_r == CW'(DATA_W - 1)) begin
              state_r     <= MEM;
              cnt_r       <= {CW{1'b0}};
              frame_err_r <= (cmd_r == 2'b11) && !rd_valid_r;
            end else begin
              cnt_r       <= cnt_r + CW'(1);
            end
          end
          MEM: begin
            case (cmd_r)
              2'b00: wr_ptr_r <= shift_r[ADDR_W-1:0];
              2'b01: if (AUTO_INC != 0) wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
              2'b10: begin
                rd_ptr_r   <= shift_r[ADDR_W-1:0];
                rd_valid_r <= 1'b1;
              end
              2'b11: if ((AUTO_INC != 0) && rd_valid_r) rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
              default: ;
            endcase
            // Read data MSB goes straight to MISO; the rest waits in tx_r.
            if (cmd_r == 2'b11) begin
              state_r <= TX;
              miso_r  <= rd_data_s[DATA_W-1];
              tx_r    <= {rd_data_s[DATA_W-2:0], 1'b0};
            end else begin
              state_r <= WAIT_SS;
            end
          end
          TX: begin
            if (cnt_r == CW'(DATA_W - 1)) begin
              state_r <= WAIT_SS;
              miso_r  <= 1'b0;
            end else begin
              miso_r  <= tx_r[DATA_W-1];
              tx_r    <= {tx_r[DATA_W-2:0], 1'b0};
              cnt_r   <= cnt_r + CW'(1);
            end
          end
          WAIT_SS: begin
            miso_r <= 1'b0;
            if (SS_n) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            miso_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign MISO      = miso_r;
  assign busy      = busy_r;
  assign frame_err = frame_err_r;

endmodule

// File: doc/spi_ram_slave_p.md
SPI_RAM_SLAVE_P -- requirements
Module: spi_ram_slave_p

Interface
REQ-001 Parameter DATA_W, default 8, payload and memory word width in bits; legal range 8..32.
REQ-002 Parameter ADDR_W, default 8, memory address width; legal range 1..DATA_W; MEM_DEPTH = 2**ADDR_W.
REQ-003 Parameter AUTO_INC, default 1, when 1 the write and read pointers post-increment after each data access.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 SS_n  input  1  active-low slave select; a frame runs while SS_n=0.
REQ-007 MOSI  input  1  serial data in, MSB first, sampled on the rising clk edge.
REQ-008 MISO  output  1  serial data out, registered, MSB first.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 frame_err  output  1  one-cycle pulse flagging a malformed or aborted frame.

Function
REQ-011 Frame format SHALL be: 2-bit cmd, then DATA_W payload bits; cmd 00=write address, 01=write data, 10=read address, 11=read data.
REQ-012 The FSM SHALL have states IDLE, CMD, PAYLOAD, MEM, TX and WAIT_SS.
- IDLE -> CMD on the first edge that samples SS_n=0.
- CMD: 2 edges capture cmd[1] then cmd[0], then -> PAYLOAD.
- PAYLOAD: DATA_W edges shift MOSI into the shift register, then -> MEM.
REQ-013 MEM SHALL last exactly one cycle and act on cmd as follows:
- 00: load wr_ptr with payload[ADDR_W-1:0].
- 01: write payload to mem[wr_ptr].
- 10: load rd_ptr with payload[ADDR_W-1:0] and set rd_valid=1.
- 11: load the TX register from mem[rd_ptr].
REQ-014 After MEM, cmd 11 SHALL go to TX; all other commands go to WAIT_SS.
REQ-015 In TX, MISO SHALL present tx[DATA_W-1] on the edge that leaves MEM and shift one bit per edge, giving DATA_W bits over DATA_W cycles, then -> WAIT_SS.
REQ-016 Read latency SHALL be one clk from the last payload (dummy) bit sample to MISO carrying the read-data MSB.
REQ-017 MISO SHALL be 0 outside TX.
REQ-018 In WAIT_SS, further MOSI bits SHALL be ignored; the FSM returns to IDLE on SS_n=1.
REQ-019 With AUTO_INC=1, wr_ptr SHALL increment after each cmd-01 MEM cycle and rd_ptr after each cmd-11 MEM cycle, wrapping MEM_DEPTH-1 -> 0.
REQ-020 With AUTO_INC=0, both pointers SHALL hold their values.
REQ-021 Upper payload bits above ADDR_W SHALL be ignored for address commands.
REQ-022 SS_n=1 sampled in CMD, PAYLOAD, MEM or TX SHALL:
- return the FSM to IDLE next cycle;
- pulse frame_err for one cycle;
- suppress any memory write or pointer update not yet performed;
- drive MISO to 0.
REQ-023 cmd 11 with rd_valid=0 SHALL:
- pulse frame_err in the MEM cycle;
- leave rd_ptr unchanged;
- transmit all-zero data.
REQ-024 SS_n falling while in WAIT_SS SHALL have no effect until SS_n has been sampled high once.
REQ-025 Memory contents SHALL NOT be reset; they are preloadable by the bench via hierarchical $readmemh on the internal array named mem.

Reset
REQ-026 While rst=1, asynchronously:
- FSM = IDLE;
- MISO = 0, busy = 0, frame_err = 0;
- wr_ptr = 0, rd_ptr = 0, rd_valid = 0;
- shift and TX registers cleared.
REQ-027 rst asserted mid-frame SHALL abort the frame with no memory write and no frame_err pulse.
REQ-028 After rst deasserts, the first frame SHALL start only on an SS_n=0 sample.

Verification (DATA_W=8, ADDR_W=8, AUTO_INC=1 unless stated)
REQ-029 Frames wr-addr 0x0F, wr-data 0xC2, rd-addr 0x0F, rd-data -> MISO = 11000010 on the 8 cycles after MEM; frame_err never asserted.
REQ-030 wr-addr 0xFF, then wr-data 0x11, 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22; rd-addr 0xFF plus two rd-data frames -> 0x11 then 0x22.
REQ-031 AUTO_INC=0: wr-addr 0x20, wr-data 0xAA, then wr-data 0x55 -> mem[0x20]=0x55 and mem[0x21] unchanged.
REQ-032 wr-data frame with SS_n raised after 4 payload bits -> frame_err pulses once, memory unchanged, busy=0 next cycle.
REQ-033 rd-data issued straight after reset -> frame_err pulse in MEM, MISO = 0 for all 8 TX cycles.
REQ-034 rst pulse in the middle of TX -> MISO = 0 at once, busy = 0, a following rd-data frame flags frame_err (rd_valid cleared).
